// File: rtl/upconverter_nco.sv
// rtl/upconverter_nco.sv - 2^k hold interpolator feeding an NCO complex mixer with rounding
// Optional UPCONV_SATURATE_EN: clamp the rounded result instead of wrapping it to WIDTH bits.
module upconverter_nco #(
    parameter int                     WIDTH             = 16,
    parameter int                     MAX_INTERP_LOG2   = 3,
    parameter int                     PHASE_WIDTH       = 32,
    parameter int                     LUT_BITS          = 10,
    parameter logic [PHASE_WIDTH-1:0] DEFAULT_PHASE_INC = '0
) (
    input  logic                                   i_clock,
    input  logic                                   i_reset_n,
    input  logic                                   i_ready,
    output logic                                   o_ready,
    input  logic signed [WIDTH-1:0]                i_inph_data,
    input  logic signed [WIDTH-1:0]                i_quad_data,
    input  logic [$clog2(MAX_INTERP_LOG2+1)-1:0]   i_interp_log2,
    input  logic [PHASE_WIDTH-1:0]                 i_phase_inc,
    input  logic                                   i_phase_inc_valid,
    output logic signed [WIDTH-1:0]                o_inph_data,
    output logic signed [WIDTH-1:0]                o_quad_data
);
    localparam int  KW       = $clog2(MAX_INTERP_LOG2 + 1);
    localparam int  CW       = (MAX_INTERP_LOG2 > 0) ? MAX_INTERP_LOG2 : 1;
    localparam int  PW       = 2 * WIDTH;
    localparam int  YW       = 2 * WIDTH + 1;
    localparam int  LUT_SIZE = 1 << LUT_BITS;
    localparam real AMP      = 2.0 ** (WIDTH - 1) - 1.0;
    localparam logic signed [YW-1:0] RND    = {{(YW-WIDTH+1){1'b0}}, 1'b1, {(WIDTH-2){1'b0}}};
    localparam logic signed [YW-1:0] SAT_HI = {{(YW-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
    localparam logic signed [YW-1:0] SAT_LO = {{(YW-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

    function automatic logic signed [WIDTH-1:0] rom_val(input int n, input bit want_sin);
        real ang;
        ang = 2.0 * 3.14159265358979323846 * real'(n) / real'(LUT_SIZE);
        return WIDTH'(int'(AMP * (want_sin ? $sin(ang) : $cos(ang))));
    endfunction

    logic signed [WIDTH-1:0] cos_rom [LUT_SIZE];
    logic signed [WIDTH-1:0] sin_rom [LUT_SIZE];

    for (genvar g = 0; g < LUT_SIZE; g++) begin : g_rom
        assign cos_rom[g] = rom_val(g, 1'b0);
        assign sin_rom[g] = rom_val(g, 1'b1);
    end

    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_last;
    logic [KW-1:0] k_act;
    logic [KW-1:0] k_next;
    logic          ready_d;

    assign k_next   = (i_interp_log2 > KW'(MAX_INTERP_LOG2)) ? KW'(MAX_INTERP_LOG2) : i_interp_log2;
    assign cnt_last = CW'((1 << k_act) - 1);

    // k is only re-sampled at the period wrap so a mid-period change never truncates a period
    always_ff @(posedge i_clock) begin
        if (!i_reset_n) begin
            cnt     <= '0;
            k_act   <= '0;
            o_ready <= 1'b0;
            ready_d <= 1'b0;
        end else begin
            ready_d <= o_ready;
            if (i_ready) begin
                if (cnt == cnt_last) begin
                    cnt     <= '0;
                    o_ready <= 1'b1;
                    k_act   <= k_next;
                end else begin
                    cnt     <= cnt + 1'b1;
                    o_ready <= 1'b0;
                end
            end else begin
                o_ready <= 1'b0;
            end
        end
    end

    logic signed [WIDTH-1:0] hold_i, hold_q;

    always_ff @(posedge i_clock) begin
        if (!i_reset_n) begin
            hold_i <= '0;
            hold_q <= '0;
        end else if (ready_d) begin
            hold_i <= i_inph_data;
            hold_q <= i_quad_data;
        end
    end

    logic [PHASE_WIDTH-1:0]  acc, inc;
    logic [LUT_BITS-1:0]     idx;
    logic signed [WIDTH-1:0] s1_i, s1_q, s1_c, s1_s;
    logic signed [PW-1:0]    s2_ic, s2_qs, s2_is, s2_qc;
    logic signed [YW-1:0]    s3_yi, s3_yq;

    assign idx = acc[PHASE_WIDTH-1 -: LUT_BITS];

    always_ff @(posedge i_clock) begin
        if (!i_reset_n) begin
            acc   <= '0;
            inc   <= DEFAULT_PHASE_INC;
            s1_i  <= '0;
            s1_q  <= '0;
            s1_c  <= '0;
            s1_s  <= '0;
            s2_ic <= '0;
            s2_qs <= '0;
            s2_is <= '0;
            s2_qc <= '0;
            s3_yi <= '0;
            s3_yq <= '0;
        end else begin
            if (i_phase_inc_valid) begin
                inc <= i_phase_inc;
            end
            if (i_ready) begin
                s1_i  <= hold_i;
                s1_q  <= hold_q;
                s1_c  <= cos_rom[idx];
                s1_s  <= sin_rom[idx];
                acc   <= acc + inc;
                s2_ic <= PW'(s1_i) * PW'(s1_c);
                s2_qs <= PW'(s1_q) * PW'(s1_s);
                s2_is <= PW'(s1_i) * PW'(s1_s);
                s2_qc <= PW'(s1_q) * PW'(s1_c);
                s3_yi <= YW'(s2_ic) - YW'(s2_qs);
                s3_yq <= YW'(s2_is) + YW'(s2_qc);
            end
        end
    end

    // round half up at the WIDTH-1 binary point
    logic signed [YW-1:0] yi_rnd, yq_rnd;
    assign yi_rnd = (s3_yi + RND) >>> (WIDTH - 1);
    assign yq_rnd = (s3_yq + RND) >>> (WIDTH - 1);

`ifdef UPCONV_SATURATE_EN
    always_comb begin
        o_inph_data = yi_rnd[WIDTH-1:0];
        o_quad_data = yq_rnd[WIDTH-1:0];
        if (yi_rnd > SAT_HI) o_inph_data = SAT_HI[WIDTH-1:0];
        if (yi_rnd < SAT_LO) o_inph_data = SAT_LO[WIDTH-1:0];
        if (yq_rnd > SAT_HI) o_quad_data = SAT_HI[WIDTH-1:0];
        if (yq_rnd < SAT_LO) o_quad_data = SAT_LO[WIDTH-1:0];
    end
`else
    logic unused_rnd;
    assign unused_rnd  = ^{yi_rnd[YW-1:WIDTH], yq_rnd[YW-1:WIDTH], SAT_HI, SAT_LO};
    assign o_inph_data = yi_rnd[WIDTH-1:0];
    assign o_quad_data = yq_rnd[WIDTH-1:0];
`endif

endmodule

// File: tb/tb_upconverter_nco.sv
// tb/tb_upconverter_nco.sv - vector, directed and randomized checks of upconverter_nco
`timescale 1ns/1ps
module tb_upconverter_nco;
    localparam int  W    = 16;
    localparam int  MAXK = 3;
    localparam int  KW   = $clog2(MAXK + 1);
    localparam real PI   = 3.14159265358979323846;
`ifdef UPCONV_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                rdy = 1'b0;
    logic                valid = 1'b0;
    logic signed [W-1:0] in_i = '0;
    logic signed [W-1:0] in_q = '0;
    logic [KW-1:0]       k_in = '0;
    logic [31:0]         inc_in = '0;
    logic                o_ready;
    logic signed [W-1:0] out_i, out_q;

    always #5 clk = ~clk;

    upconverter_nco dut (
        .i_clock           (clk),
        .i_reset_n         (rst_n),
        .i_ready           (rdy),
        .o_ready           (o_ready),
        .i_inph_data       (in_i),
        .i_quad_data       (in_q),
        .i_interp_log2     (k_in),
        .i_phase_inc       (inc_in),
        .i_phase_inc_valid (valid),
        .o_inph_data       (out_i),
        .o_quad_data       (out_q)
    );

    int total = 0;
    int bad = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Behavioural model: a sample entering the mixer is described by (I, Q, table index);
    // the output after the n-th enabled cycle is the mix of the entry taken two enabled cycles earlier.
    typedef struct { longint i; longint q; int idx; } pent_t;
    pent_t       m_pipe[$];
    longint      m_hold_i, m_hold_q, m_out_i, m_out_q;
    logic [31:0] m_acc, m_inc;
    bit          m_ordy, m_ordy_prev;
    int          m_pos, m_k;

    function automatic longint lut(input int n, input bit want_sin);
        real a;
        a = 2.0 * PI * real'(n) / 1024.0;
        return longint'(int'(32767.0 * (want_sin ? $sin(a) : $cos(a))));
    endfunction

    function automatic longint reduce(input longint y);
        longint r;
        r = (y + 16384) >>> 15;
        if (SAT) begin
            if (r > 32767) r = 32767;
            if (r < -32768) r = -32768;
        end else begin
            r = r & 65535;
            if (r >= 32768) r = r - 65536;
        end
        return r;
    endfunction

    task automatic model_edge();
        pent_t e, o;
        bit    capture, new_ordy;
        if (!rst_n) begin
            m_pipe.delete();
            m_pipe.push_back('{0, 0, 0});
            m_pipe.push_back('{0, 0, 0});
            m_hold_i = 0; m_hold_q = 0; m_out_i = 0; m_out_q = 0;
            m_acc = '0; m_inc = '0; m_ordy = 0; m_ordy_prev = 0; m_pos = 0; m_k = 0;
        end else begin
            capture  = m_ordy_prev;
            new_ordy = 0;
            if (rdy) begin
                e = '{m_hold_i, m_hold_q, int'(m_acc >> 22)};
                m_pipe.push_back(e);
                o = m_pipe.pop_front();
                m_out_i = reduce(o.i * lut(o.idx, 0) - o.q * lut(o.idx, 1));
                m_out_q = reduce(o.i * lut(o.idx, 1) + o.q * lut(o.idx, 0));
                m_acc = m_acc + m_inc;
                m_pos++;
                if (m_pos == (1 << m_k)) begin
                    new_ordy = 1;
                    m_pos = 0;
                    m_k = (int'(k_in) > MAXK) ? MAXK : int'(k_in);
                end
            end
            if (valid) m_inc = inc_in;
            if (capture) begin
                m_hold_i = longint'(in_i);
                m_hold_q = longint'(in_q);
            end
            m_ordy_prev = m_ordy;
            m_ordy = new_ordy;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        chk("model_ready", longint'(o_ready), longint'(m_ordy));
        chk("model_out_i", longint'(out_i), m_out_i);
        chk("model_out_q", longint'(out_q), m_out_q);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    typedef struct { int i; int q; int ei; int eq; } vec_t;
    vec_t vt[5];

    initial begin
        int pulses, gap_err, last, mag2, n;
        int pe[5];

        vt[0] = '{32767, 0, 32766, 0};
        vt[1] = '{16384, -16384, 16384, -16383};
        vt[2] = '{-32768, -32768, -32767, -32767};
        vt[3] = '{1, -1, 1, -1};
        vt[4] = '{0, 12345, 0, 12345};

        // reset state, with i_ready held high
        @(negedge clk);
        rdy = 1'b1;
        rst_n = 1'b0;
        tick();
        tick();
        chk("reset_ready", longint'(o_ready), 0);
        chk("reset_out_i", longint'(out_i), 0);
        chk("reset_out_q", longint'(out_q), 0);

        // DC vectors at phase 0, then hold with i_ready low
        foreach (vt[v]) begin
            rdy = 1'b0;
            do_reset();
            k_in = KW'(2); inc_in = '0; valid = 1'b0;
            in_i = W'(vt[v].i); in_q = W'(vt[v].q);
            rdy = 1'b1;
            repeat (30) tick();
            chk("vec_i", longint'(out_i), longint'(vt[v].ei));
            chk("vec_q", longint'(out_q), longint'(vt[v].eq));
            rdy = 1'b0;
            repeat (5) tick();
            chk("vec_hold_i", longint'(out_i), longint'(vt[v].ei));
            chk("vec_hold_q", longint'(out_q), longint'(vt[v].eq));
        end

        // o_ready pulse count and spacing at k=2
        do_reset();
        k_in = KW'(2); rdy = 1'b1;
        pulses = 0; gap_err = 0; last = -1;
        for (int c = 0; c < 10000; c++) begin
            tick();
            if (o_ready) begin
                if (last >= 0 && c - last != 4) gap_err++;
                last = c;
                pulses++;
            end
        end
        chk("count_pulses", pulses, 2500);
        chk("count_gap_errors", gap_err, 0);
        rdy = 1'b0;
        pulses = 0;
        repeat (50) begin
            tick();
            if (o_ready) pulses++;
        end
        chk("idle_pulses", pulses, 0);

        // k=1 -> k=3 mid-period
        do_reset();
        k_in = KW'(1); rdy = 1'b1;
        n = 0;
        foreach (pe[j]) pe[j] = -100;
        for (int c = 0; c < 40; c++) begin
            tick();
            if (o_ready && n < 5) begin
                pe[n] = c;
                n++;
                if (n == 2) k_in = KW'(3);
            end
        end
        chk("interp_gap_k1", pe[1] - pe[0], 2);
        chk("interp_gap_finish", pe[2] - pe[1], 2);
        chk("interp_gap_k3a", pe[3] - pe[2], 8);
        chk("interp_gap_k3b", pe[4] - pe[3], 8);

        // saturation/wrap at 135 and 45 degrees
        rdy = 1'b0;
        do_reset();
        inc_in = 32'h2000_0000; valid = 1'b1;
        tick();
        valid = 1'b0;
        k_in = '0;
        in_i = -16'sd32768; in_q = -16'sd32768;
        rdy = 1'b1;
        repeat (6) tick();
        chk("sat135_i", longint'(out_i), SAT ? 32767 : -19196);
        chk("sat135_q", longint'(out_q), 0);
        repeat (6) tick();
        chk("sat45_i", longint'(out_i), 0);
        chk("sat45_q", longint'(out_q), SAT ? -32768 : 19196);

        // tone at fs/16 with a one-cycle reset in the middle
        rdy = 1'b0;
        do_reset();
        inc_in = 32'h1000_0000; valid = 1'b1;
        tick();
        valid = 1'b0;
        k_in = KW'(2); in_i = 16'sd16384; in_q = '0; rdy = 1'b1;
        for (int c = 0; c < 400; c++) begin
            tick();
            if (c >= 20) begin
                mag2 = int'(out_i) * int'(out_i) + int'(out_q) * int'(out_q);
                chk("tone_magnitude_ok", longint'(mag2 >= 16382 * 16382 && mag2 <= 16385 * 16385), 1);
            end
        end
        rst_n = 1'b0;
        tick();
        chk("midreset_ready", longint'(o_ready), 0);
        chk("midreset_out_i", longint'(out_i), 0);
        chk("midreset_out_q", longint'(out_q), 0);
        rst_n = 1'b1;
        tick();
        chk("midreset_first_ready", longint'(o_ready), 1);
        repeat (100) tick();

        // randomized traffic against the model
        for (int c = 0; c < 3000; c++) begin
            rdy    = ($urandom_range(0, 3) != 0);
            in_i   = W'($urandom);
            in_q   = W'($urandom);
            k_in   = KW'($urandom_range(0, MAXK));
            valid  = ($urandom_range(0, 15) == 0);
            inc_in = $urandom;
            rst_n  = ($urandom_range(0, 499) != 0);
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
